// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_pkg
// Description : Shared definitions for the multi-cycle MIPS-31 control unit.
//               It holds the opcode/funct codes, ALU operation codes, the PC
//               and write-back source encodings, the FSM state type and the
//               decoded-instruction record passed from decoder to FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_controller_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_addiu = 6'h09;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_sltiu = 6'h0B;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_xori  = 6'h0E;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    // R-type function codes, instruction bits [5:0]
    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_sra  = 6'h03;
    localparam logic [5:0] c_fn_sllv = 6'h04;
    localparam logic [5:0] c_fn_srlv = 6'h06;
    localparam logic [5:0] c_fn_srav = 6'h07;
    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_xor  = 6'h26;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2A;
    localparam logic [5:0] c_fn_sltu = 6'h2B;

    // ALU operation codes
    localparam logic [3:0] c_alu_add  = 4'h0;
    localparam logic [3:0] c_alu_addu = 4'h1;
    localparam logic [3:0] c_alu_sub  = 4'h2;
    localparam logic [3:0] c_alu_subu = 4'h3;
    localparam logic [3:0] c_alu_and  = 4'h4;
    localparam logic [3:0] c_alu_or   = 4'h5;
    localparam logic [3:0] c_alu_xor  = 4'h6;
    localparam logic [3:0] c_alu_nor  = 4'h7;
    localparam logic [3:0] c_alu_slt  = 4'h8;
    localparam logic [3:0] c_alu_sltu = 4'h9;
    localparam logic [3:0] c_alu_sll  = 4'hA;
    localparam logic [3:0] c_alu_srl  = 4'hB;
    localparam logic [3:0] c_alu_sra  = 4'hC;
    localparam logic [3:0] c_alu_lui  = 4'hD;

    // PC source select
    localparam logic [1:0] c_pc_plus4  = 2'b00;
    localparam logic [1:0] c_pc_branch = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;
    localparam logic [1:0] c_pc_rs     = 2'b11;

    // Register write-back source select
    localparam logic [1:0] c_rd_alu  = 2'b00;
    localparam logic [1:0] c_rd_mem  = 2'b01;
    localparam logic [1:0] c_rd_link = 2'b10;

    localparam logic [4:0] c_link_reg = 5'd31;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    // Instruction class flags plus datapath selects, produced by the decoder
    typedef struct packed {
        logic       illegal;
        logic       is_branch;
        logic       is_j;
        logic       is_jal;
        logic       is_jr;
        logic       is_lw;
        logic       is_sw;
        logic       rs_rena;
        logic       rt_rena;
        logic [4:0] rd_addr;
        logic [1:0] rd_sel;
        logic       ext_signed;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [3:0] alu_sel;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/mips_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mips_decoder
// Description : Purely combinational MIPS-31 instruction decoder. Classifies
//               the instruction and produces register-read enables, the
//               destination register, write-back source and ALU controls.
//               No state gating happens here; the controller does that.
// Ports       : i_instruction  32  instruction register contents
//               o_dec          --  decoded fields (dec_t)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [31:0] i_instruction,
    output dec_t        o_dec
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused;

    assign w_op = i_instruction[31:26];
    assign w_fn = i_instruction[5:0];
    assign w_rt = i_instruction[20:16];
    assign w_rd = i_instruction[15:11];

    // rs number, shamt and immediate are routed by the datapath directly
    assign w_unused = ^{i_instruction[25:21], i_instruction[10:6]};

    always_comb begin
        o_dec = '0;
        case (w_op)
            c_op_rtype: begin
                o_dec.rd_addr = w_rd;
                o_dec.rs_rena = 1'b1;
                o_dec.rt_rena = 1'b1;
                case (w_fn)
                    c_fn_add:  o_dec.alu_sel = c_alu_add;
                    c_fn_addu: o_dec.alu_sel = c_alu_addu;
                    c_fn_sub:  o_dec.alu_sel = c_alu_sub;
                    c_fn_subu: o_dec.alu_sel = c_alu_subu;
                    c_fn_and:  o_dec.alu_sel = c_alu_and;
                    c_fn_or:   o_dec.alu_sel = c_alu_or;
                    c_fn_xor:  o_dec.alu_sel = c_alu_xor;
                    c_fn_nor:  o_dec.alu_sel = c_alu_nor;
                    c_fn_slt:  o_dec.alu_sel = c_alu_slt;
                    c_fn_sltu: o_dec.alu_sel = c_alu_sltu;
                    c_fn_sllv: o_dec.alu_sel = c_alu_sll;
                    c_fn_srlv: o_dec.alu_sel = c_alu_srl;
                    c_fn_srav: o_dec.alu_sel = c_alu_sra;
                    // Constant shifts take the amount from shamt, not rs
                    c_fn_sll, c_fn_srl, c_fn_sra: begin
                        o_dec.rs_rena   = 1'b0;
                        o_dec.alu_a_sel = 1'b1;
                        o_dec.alu_sel   = (w_fn == c_fn_sll) ? c_alu_sll :
                                          (w_fn == c_fn_srl) ? c_alu_srl : c_alu_sra;
                    end
                    c_fn_jr: begin
                        o_dec.is_jr   = 1'b1;
                        o_dec.rt_rena = 1'b0;
                        o_dec.rd_addr = 5'd0;
                    end
                    default: o_dec.illegal = 1'b1;
                endcase
            end
            c_op_addi, c_op_addiu, c_op_slti, c_op_sltiu,
            c_op_andi, c_op_ori, c_op_xori, c_op_lui: begin
                o_dec.rs_rena   = (w_op != c_op_lui);
                o_dec.rd_addr   = w_rt;
                o_dec.alu_b_sel = 1'b1;
                case (w_op)
                    c_op_addi:  begin o_dec.alu_sel = c_alu_add;  o_dec.ext_signed = 1'b1; end
                    c_op_addiu: begin o_dec.alu_sel = c_alu_addu; o_dec.ext_signed = 1'b1; end
                    c_op_slti:  begin o_dec.alu_sel = c_alu_slt;  o_dec.ext_signed = 1'b1; end
                    c_op_sltiu: begin o_dec.alu_sel = c_alu_sltu; o_dec.ext_signed = 1'b1; end
                    c_op_andi:  o_dec.alu_sel = c_alu_and;
                    c_op_ori:   o_dec.alu_sel = c_alu_or;
                    c_op_xori:  o_dec.alu_sel = c_alu_xor;
                    default:    o_dec.alu_sel = c_alu_lui;
                endcase
            end
            c_op_lw: begin
                o_dec.is_lw      = 1'b1;
                o_dec.rs_rena    = 1'b1;
                o_dec.rd_addr    = w_rt;
                o_dec.rd_sel     = c_rd_mem;
                o_dec.ext_signed = 1'b1;
                o_dec.alu_b_sel  = 1'b1;
                o_dec.alu_sel    = c_alu_addu;
            end
            c_op_sw: begin
                o_dec.is_sw      = 1'b1;
                o_dec.rs_rena    = 1'b1;
                o_dec.rt_rena    = 1'b1;
                o_dec.ext_signed = 1'b1;
                o_dec.alu_b_sel  = 1'b1;
                o_dec.alu_sel    = c_alu_addu;
            end
            c_op_beq, c_op_bne: begin
                // The ALU compare result arrives back as in_branch
                o_dec.is_branch  = 1'b1;
                o_dec.rs_rena    = 1'b1;
                o_dec.rt_rena    = 1'b1;
                o_dec.ext_signed = 1'b1;
                o_dec.alu_sel    = c_alu_subu;
            end
            c_op_j: o_dec.is_j = 1'b1;
            c_op_jal: begin
                o_dec.is_jal  = 1'b1;
                o_dec.rd_addr = c_link_reg;
                o_dec.rd_sel  = c_rd_link;
            end
            default: o_dec.illegal = 1'b1;
        endcase

        // Keep illegal encodings from leaking partial selects downstream
        if (o_dec.illegal) begin
            o_dec         = '0;
            o_dec.illegal = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle MIPS-31 control unit. Sequences FETCH, DECODE,
//               EXEC, MEM and WB per instruction, handshakes with a shared
//               memory via in_mem_ready, and traps on illegal instructions or
//               on a memory stall longer than MEM_WAIT_MAX cycles.
// Ports       : in_clk, in_rst_n            clock / async active-low reset
//               in_instruction, in_branch   IR contents, ALU branch result
//               in_mem_ready                memory completed request
//               out_ir_wena .. out_alu_sel  datapath control
//               out_state                   current FSM state
//               out_illegal, out_mem_timeout sticky trap causes
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX    = 15,
    parameter int unsigned WAIT_CNT_W      = 8,
    parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [31:0] in_instruction,
    input  logic        in_branch,
    input  logic        in_mem_ready,
    output logic        out_ir_wena,
    output logic        out_pc_wena,
    output logic [1:0]  out_pc_sel,
    output logic        out_mem_req,
    output logic        out_mem_wena,
    output logic        out_mem_addr_sel,
    output logic        out_rs_rena,
    output logic        out_rt_rena,
    output logic        out_rd_wena,
    output logic [4:0]  out_rd_addr,
    output logic [1:0]  out_rd_sel,
    output logic        out_ext_signed,
    output logic        out_alu_a_sel,
    output logic        out_alu_b_sel,
    output logic [3:0]  out_alu_sel,
    output logic [2:0]  out_state,
    output logic        out_illegal,
    output logic        out_mem_timeout
);

    localparam logic [WAIT_CNT_W-1:0] c_wait_last = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_illegal;
    logic                  r_mem_timeout;

    dec_t       w_dec;
    logic       w_dec_valid;
    logic       w_dec_out;
    logic       w_wait_expired;
    logic       w_set_illegal;
    logic       w_set_timeout;
    logic       w_ir_wena;
    logic       w_pc_wena;
    logic [1:0] w_pc_sel;
    logic       w_mem_req;
    logic       w_mem_wena;
    logic       w_addr_sel;
    logic       w_rd_wena;

    mips_decoder u_decoder (
        .i_instruction (in_instruction),
        .o_dec         (w_dec)
    );

    // Last allowed waiting cycle: without ready now, the stall has lasted
    // MEM_WAIT_MAX cycles.
    assign w_wait_expired = (r_wait_cnt == c_wait_last);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_FETCH || r_state == ST_MEM) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_illegal     <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        w_ir_wena     = 1'b0;
        w_pc_wena     = 1'b0;
        w_pc_sel      = c_pc_plus4;
        w_mem_req     = 1'b0;
        w_mem_wena    = 1'b0;
        w_addr_sel    = 1'b0;
        w_rd_wena     = 1'b0;
        w_dec_valid   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (in_mem_ready) begin
                    w_ir_wena    = 1'b1;
                    w_pc_wena    = 1'b1;
                    w_next_state = ST_DECODE;
                end else if (w_wait_expired) begin
                    w_set_timeout = 1'b1;
                    w_next_state  = ST_TRAP;
                end
            end
            ST_DECODE: begin
                w_dec_valid = 1'b1;
                if (w_dec.illegal) begin
                    if (TRAP_ON_ILLEGAL != 0) begin
                        w_set_illegal = 1'b1;
                        w_next_state  = ST_TRAP;
                    end else begin
                        w_next_state = ST_FETCH;
                    end
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_dec_valid = 1'b1;
                if (w_dec.is_branch) begin
                    w_pc_wena    = in_branch;
                    w_pc_sel     = c_pc_branch;
                    w_next_state = ST_FETCH;
                end else if (w_dec.is_j || w_dec.is_jal) begin
                    w_pc_wena    = 1'b1;
                    w_pc_sel     = c_pc_jump;
                    w_next_state = w_dec.is_jal ? ST_WB : ST_FETCH;
                end else if (w_dec.is_jr) begin
                    w_pc_wena    = 1'b1;
                    w_pc_sel     = c_pc_rs;
                    w_next_state = ST_FETCH;
                end else if (w_dec.is_lw || w_dec.is_sw) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_MEM: begin
                w_dec_valid = 1'b1;
                w_mem_req   = 1'b1;
                w_addr_sel  = 1'b1;
                w_mem_wena  = w_dec.is_sw;
                if (in_mem_ready) begin
                    w_next_state = w_dec.is_lw ? ST_WB : ST_FETCH;
                end else if (w_wait_expired) begin
                    w_set_timeout = 1'b1;
                    w_next_state  = ST_TRAP;
                end
            end
            ST_WB: begin
                w_dec_valid  = 1'b1;
                w_rd_wena    = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_TRAP: w_next_state = ST_TRAP;
            default: w_next_state = ST_FETCH;
        endcase
    end

    // While reset is held every output is forced low, so an in-flight memory
    // write is withdrawn in the same instant rather than at the next edge.
    assign w_dec_out = w_dec_valid & in_rst_n;

    assign out_ir_wena      = w_ir_wena  & in_rst_n;
    assign out_pc_wena      = w_pc_wena  & in_rst_n;
    assign out_pc_sel       = in_rst_n ? w_pc_sel : c_pc_plus4;
    assign out_mem_req      = w_mem_req  & in_rst_n;
    assign out_mem_wena     = w_mem_wena & in_rst_n;
    assign out_mem_addr_sel = w_addr_sel & in_rst_n;
    assign out_rd_wena      = w_rd_wena  & in_rst_n;

    assign out_rs_rena    = w_dec.rs_rena    & w_dec_out;
    assign out_rt_rena    = w_dec.rt_rena    & w_dec_out;
    assign out_ext_signed = w_dec.ext_signed & w_dec_out;
    assign out_alu_a_sel  = w_dec.alu_a_sel  & w_dec_out;
    assign out_alu_b_sel  = w_dec.alu_b_sel  & w_dec_out;
    assign out_rd_addr    = w_dec_out ? w_dec.rd_addr : 5'd0;
    assign out_rd_sel     = w_dec_out ? w_dec.rd_sel  : c_rd_alu;
    assign out_alu_sel    = w_dec_out ? w_dec.alu_sel : c_alu_add;

    assign out_state       = r_state;
    assign out_illegal     = r_illegal;
    assign out_mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
FSM-based control unit for the multi-cycle MIPS-31 datapath, replacing the single-cycle combinational decoder. It sequences FETCH/DECODE/EXEC/MEM/WB per instruction and handshakes with a shared instruction/data memory through a ready signal. A watchdog raises a timeout if memory stalls too long. Beyond the single-cycle unit it also handles jr (PC from rs), jal link-write to $31, illegal-opcode trapping and variable memory latency. It sits between the instruction register and the datapath muxes/ALU/register file.

Parameters:
MEM_WAIT_MAX, 15, max cycles waiting on in_mem_ready in FETCH or MEM before the timeout trap (1..255)
WAIT_CNT_W, 8, width of the wait counter; must satisfy 2^WAIT_CNT_W > MEM_WAIT_MAX
TRAP_ON_ILLEGAL, 1, 1 = unknown opcode/func enters TRAP; 0 = treated as NOP (back to FETCH)

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_instruction  input  32  IR contents, valid from DECODE onward
in_branch  input  1  branch condition from ALU (eq for beq, ne for bne), valid in EXEC
in_mem_ready  input  1  memory completed current request this cycle
out_ir_wena  output  1  load IR from memory read data
out_pc_wena  output  1  PC write enable
out_pc_sel  output  2  00 pc+4, 01 branch target, 10 jump target, 11 rs (jr)
out_mem_req  output  1  memory request active
out_mem_wena  output  1  memory write (sw)
out_mem_addr_sel  output  1  0 PC, 1 ALU result
out_rs_rena  output  1  read rs
out_rt_rena  output  1  read rt
out_rd_wena  output  1  register file write enable
out_rd_addr  output  5  destination: rd (R-type), rt (I-type), 31 (jal)
out_rd_sel  output  2  write-back source: 00 ALU, 01 memory data, 10 pc+4
out_ext_signed  output  1  sign-extend immediate
out_alu_a_sel  output  1  1 = shamt for sll/srl/sra
out_alu_b_sel  output  1  1 = extended immediate
out_alu_sel  output  4  ADD 0000 ADDU 0001 SUB 0010 SUBU 0011 AND 0100 OR 0101 XOR 0110 NOR 0111 SLT 1000 SLTU 1001 SLL/SLLV 1010 SRL/SRLV 1011 SRA/SRAV 1100 LUI 1101
out_state  output  3  current state, for debug
out_illegal  output  1  sticky: trapped on illegal instruction
out_mem_timeout  output  1  sticky: trapped on memory timeout

Behaviour:
- States: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7. Reset -> FETCH; all outputs 0, out_rd_addr 0, wait counter 0, sticky flags cleared.
- FETCH: mem_req=1, addr_sel=0. When in_mem_ready=1: ir_wena=1, pc_wena=1, pc_sel=00; go to DECODE. Otherwise stay and increment the counter.
- DECODE: one cycle. rs_rena and rt_rena are asserted as in the single-cycle decoder. Illegal op/func goes to TRAP when TRAP_ON_ILLEGAL=1, else to FETCH.
- EXEC: ALU controls are valid.
  - beq/bne: pc_wena = in_branch, pc_sel=01; then FETCH.
  - j/jal: pc_wena=1, pc_sel=10. j goes to FETCH; jal goes to WB with rd_addr 31, rd_sel 10.
  - jr: pc_wena=1, pc_sel=11; then FETCH.
  - lw/sw go to MEM. All others go to WB.
- MEM: mem_req=1, addr_sel=1, mem_wena=sw. Stays until in_mem_ready. sw then goes to FETCH; lw goes to WB with rd_sel=01.
- WB: rd_wena=1 for one cycle; then FETCH.
- Cycle counts with zero wait: R/I ALU ops 4; lw 5; sw 4; branch/j/jr 3; jal 4.
- Decode outputs are combinational from in_instruction but are gated: rd_wena only in WB, mem_req only in FETCH/MEM, pc_wena only as listed above.
- Wait counter is cleared on every state entry. A count reaching MEM_WAIT_MAX while still waiting goes to TRAP and sets out_mem_timeout. in_mem_ready on that same cycle wins: normal transition, no trap.
- TRAP is absorbing: no enables asserted, only reset exits it.
- Reset asserted mid-operation returns to FETCH immediately (asynchronously); an in-flight write is dropped.
- sll/srl/sra: rs_rena=0, alu_a_sel=1. lui: alu_sel 1101, no rs read.

Decomposition:
- Shared package: opcode/func localparams, ALU op codes, pc_sel/rd_sel encodings, state encoding.
- One natural sub-module: mips_decoder (combinational instruction -> class flags and datapath selects). The FSM plus counter remain in multicycle_controller.

Test Plan:
- addu $3,$1,$2 (0x00221821), ready always 1 -> states 0,1,2,4, then 0; in WB rd_wena=1, rd_addr=3, alu_sel=0001, rd_sel=00.
- lw $5,4($1) (0x8C250004), ready low 2 cycles in MEM -> MEM held 3 cycles with addr_sel=1, mem_wena=0; WB rd_addr=5, rd_sel=01; total 7 cycles.
- beq $1,$2,+4 (0x10220004) with in_branch=1, then =0 -> EXEC pc_wena=1/pc_sel=01, then pc_wena=0; back to FETCH after 3 cycles.
- jal 0x0C000010 then jr $31 (0x03E00008) -> jal: pc_sel=10 then WB rd_addr=31, rd_sel=10. jr: rs_rena=1, pc_sel=11.
- FETCH with ready stuck low, MEM_WAIT_MAX=15 -> TRAP entered after 15 waiting cycles, out_mem_timeout=1, no further enables. Ready on cycle 15 instead -> no trap. Reset clears the flag.
- Opcode 0x3F (0xFC000000) -> TRAP after DECODE, out_illegal=1. Asserting in_rst_n=0 during MEM of sw -> mem_req drops at once, state 0 on release.
